// File: rtl/sortmax_key_loader.sv
// sortmax_key_loader
// Loads a serial key frame (KEYW data bits LSB first, then one odd-parity
// bit) into a shadow register, and only after the parity check passes
// transfers it to the locked FSM's key bus.  The locked FSM is held in
// reset for RST_HOLD cycles after the key is applied, and is then released.
//
// Ports:
//   clk       - single clock, rising edge
//   rst       - asynchronous active-high reset
//   key_sin   - serial key data, LSB first
//   key_sen   - serial enable; key_sin sampled only when high
//   relock    - clears the key and returns to IDLE (highest priority)
//   keyinput  - key bus to the locked FSM (only ever a fully checked key or 0)
//   fsm_rst   - active-high reset to the locked FSM (low only in RUN)
//   key_valid - high in RUN
//   key_err   - high in ERR (parity failure)
//   busy      - high in LOAD, CHECK and HOLD
//   dbg_state - current FSM state encoding, for observation only
//
// Handshake: there is no backpressure.  A serial bit transfers on every
// rising edge where key_sen=1 while the block is in IDLE or LOAD; in all
// other states key_sen/key_sin are ignored.
module sortmax_key_loader #(
  parameter int KEYW     = 8,
  parameter int RST_HOLD = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_sin,
  input  logic            key_sen,
  input  logic            relock,
  output logic [KEYW-1:0] keyinput,
  output logic            fsm_rst,
  output logic            key_valid,
  output logic            key_err,
  output logic            busy,
  output logic [2:0]      dbg_state
);

  localparam int CW = $clog2(KEYW + 1);
  localparam int HW = $clog2(RST_HOLD + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    HOLD  = 3'd3,
    RUN   = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t          state;
  logic [KEYW-1:0] shadow;
  logic [CW-1:0]   count;
  logic            par_bit;
  logic [HW-1:0]   hold_cnt;

  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shadow    <= '0;
      count     <= '0;
      par_bit   <= 1'b0;
      hold_cnt  <= '0;
      keyinput  <= '0;
      fsm_rst   <= 1'b1;
      key_valid <= 1'b0;
      key_err   <= 1'b0;
      busy      <= 1'b0;
    end else if (relock) begin
      // relock wins over everything, including a parity sample this cycle.
      state     <= IDLE;
      shadow    <= '0;
      count     <= '0;
      par_bit   <= 1'b0;
      hold_cnt  <= '0;
      keyinput  <= '0;
      fsm_rst   <= 1'b1;
      key_valid <= 1'b0;
      key_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (key_sen) begin
            shadow <= KEYW'(key_sin);
            count  <= CW'(1);
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end

        LOAD: begin
          if (key_sen) begin
            if (count == CW'(KEYW)) begin
              par_bit <= key_sin;
              state   <= CHECK;
            end else begin
              // Shadow bits above count are still zero, so OR-in is a store.
              shadow <= shadow | (KEYW'(key_sin) << count);
              count  <= count + CW'(1);
            end
          end
        end

        CHECK: begin
          // Odd parity across data and parity bits.
          if (((^shadow) ^ par_bit) == 1'b1) begin
            keyinput <= shadow;
            hold_cnt <= HW'(RST_HOLD);
            state    <= HOLD;
          end else begin
            key_err <= 1'b1;
            busy    <= 1'b0;
            state   <= ERR;
          end
        end

        HOLD: begin
          if (hold_cnt == HW'(1)) begin
            fsm_rst   <= 1'b0;
            key_valid <= 1'b1;
            busy      <= 1'b0;
            hold_cnt  <= '0;
            state     <= RUN;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end

        RUN: begin
          state <= RUN;
        end

        ERR: begin
          state <= ERR;
        end

        default: begin
          state     <= IDLE;
          shadow    <= '0;
          count     <= '0;
          keyinput  <= '0;
          fsm_rst   <= 1'b1;
          key_valid <= 1'b0;
          key_err   <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sortmax_key_loader.sv
// Testbench for sortmax_key_loader (KEYW=8, RST_HOLD=2).
// Expected outputs come from a cycle model driven by the frame rules:
// data bits, odd parity over all bits, key on the bus one edge after the
// parity sample, release RST_HOLD edges later.
module tb_sortmax_key_loader;

  localparam int KEYW     = 8;
  localparam int RST_HOLD = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            key_sin = 1'b0;
  logic            key_sen = 1'b0;
  logic            relock = 1'b0;
  logic [KEYW-1:0] keyinput;
  logic            fsm_rst;
  logic            key_valid;
  logic            key_err;
  logic            busy;
  logic [2:0]      dbg_state;

  int checks = 0;
  int failures = 0;

  // Model of the expected outputs.
  logic [KEYW-1:0] m_key = '0;
  logic            m_valid = 1'b0;
  logic            m_err = 1'b0;
  logic            m_busy = 1'b0;
  logic            m_fsm_rst = 1'b1;

  sortmax_key_loader #(.KEYW(KEYW), .RST_HOLD(RST_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_sin   (key_sin),
    .key_sen   (key_sen),
    .relock    (relock),
    .keyinput  (keyinput),
    .fsm_rst   (fsm_rst),
    .key_valid (key_valid),
    .key_err   (key_err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string ph);
    chk({ph, ".keyinput"},  32'(keyinput),  32'(m_key));
    chk({ph, ".fsm_rst"},   32'(fsm_rst),   32'(m_fsm_rst));
    chk({ph, ".key_valid"}, 32'(key_valid), 32'(m_valid));
    chk({ph, ".key_err"},   32'(key_err),   32'(m_err));
    chk({ph, ".busy"},      32'(busy),      32'(m_busy));
  endtask

  task automatic model_idle();
    m_key = '0; m_valid = 1'b0; m_err = 1'b0; m_busy = 1'b0; m_fsm_rst = 1'b1;
  endtask

  // Drivers: apply inputs, take one rising edge, sample 1 ns later.
  task automatic send(input logic sen, input logic sin);
    key_sen = sen;
    key_sin = sin;
    @(posedge clk);
    #1;
  endtask

  task automatic relock_pulse(input string ph);
    relock = 1'b1;
    send(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
    relock = 1'b0;
    key_sen = 1'b0;
    model_idle();
    check_outs(ph);
  endtask

  // One complete frame.  stall_pos: data index before which key_sen is held
  // low for stall_len cycles (-1 for none).  relock_par: relock rides on the
  // parity sample.
  task automatic run_frame(input string ph, input logic [KEYW-1:0] key, input logic par,
                           input int stall_pos, input int stall_len, input bit relock_par);
    bit pass;
    pass = ((^key) ^ par) == 1'b1;
    for (int i = 0; i < KEYW; i++) begin
      if (i == stall_pos) begin
        for (int s = 0; s < stall_len; s++) begin
          send(1'b0, logic'($urandom_range(0, 1)));
          m_busy = (i > 0);
          check_outs({ph, ".stall"});
        end
      end
      send(1'b1, key[i]);
      m_busy = 1'b1;
      check_outs({ph, ".load"});
    end
    relock = relock_par;
    send(1'b1, par);
    relock = 1'b0;
    if (relock_par) begin
      model_idle();
      check_outs({ph, ".relock_par"});
      send(1'b0, 1'b0);
      check_outs({ph, ".after_relock_par"});
      return;
    end
    check_outs({ph, ".check"});
    // From here on the serial inputs must be ignored; drive noise.
    send(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
    if (pass) m_key = key;
    else begin
      m_err = 1'b1;
      m_busy = 1'b0;
    end
    check_outs({ph, ".post_check"});
    if (pass) begin
      for (int h = 1; h <= RST_HOLD; h++) begin
        send(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
        if (h == RST_HOLD) begin
          m_valid = 1'b1;
          m_fsm_rst = 1'b0;
          m_busy = 1'b0;
        end
        check_outs({ph, ".hold"});
      end
    end
    for (int k = 0; k < 3; k++) begin
      send(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
      check_outs({ph, ".steady"});
    end
    key_sen = 1'b0;
  endtask

  initial begin
    // Reset held across a few edges.
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset");
    #3 rst = 1'b0;
    send(1'b0, 1'b1);
    check_outs("idle");

    // relock in IDLE has no visible effect.
    relock_pulse("idle_relock");

    // Good 0xA5 frame, odd parity bit 1.
    run_frame("a5_good", 8'hA5, 1'b1, -1, 0, 1'b0);
    relock_pulse("a5_good_relock");

    // Same key, wrong parity -> ERR; relock clears key_err.
    run_frame("a5_bad", 8'hA5, 1'b0, -1, 0, 1'b0);
    relock_pulse("a5_bad_relock");

    // Stall of 3 cycles between bits 3 and 4.
    run_frame("a5_stall", 8'hA5, 1'b1, 4, 3, 1'b0);
    relock_pulse("a5_stall_relock");

    // Async reset after 5 bits, checked between clock edges.
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 1'b1);
      m_busy = 1'b1;
      check_outs("abort.load");
    end
    #2 rst = 1'b1;
    #1;
    model_idle();
    check_outs("abort.async_rst");
    #1 rst = 1'b0;
    send(1'b0, 1'b0);
    check_outs("abort.idle");
    run_frame("3c_after_abort", 8'h3C, 1'b1, -1, 0, 1'b0);

    // relock while running, then an all-ones key.
    relock_pulse("3c_relock");
    run_frame("a5_run", 8'hA5, 1'b1, -1, 0, 1'b0);
    relock_pulse("run_relock");
    run_frame("ff_good", 8'hFF, 1'b1, -1, 0, 1'b0);
    relock_pulse("ff_relock");

    // relock on the parity sample wins.
    run_frame("relock_parity", 8'hA5, 1'b1, -1, 0, 1'b1);

    // Random frames.
    for (int n = 0; n < 20; n++) begin
      logic [KEYW-1:0] rk;
      logic            rp;
      int              sp;
      rk = KEYW'($urandom);
      rp = logic'($urandom_range(0, 1));
      sp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, KEYW - 1)) : -1;
      run_frame("rand", rk, rp, sp, int'($urandom_range(1, 4)),
                ($urandom_range(0, 7) == 0));
      relock_pulse("rand_relock");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
